csr_rw_unit: RTL

CSR_RW_UNIT -- requirements
Module: csr_rw_unit

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_cycle_cnt.sv | 17 +
 rtl/csr_rw_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, op encodings, FSM states and WARL masks.
package csr_pkg;

  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;

  localparam logic [1:0] CSR_RW = 2'b01;
  localparam logic [1:0] CSR_RS = 2'b10;
  localparam logic [1:0] CSR_RC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  localparam logic [63:0] MTVEC_WARL    = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] MEPC_WARL     = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] MSCRATCH_WARL = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] csr_new_val(input logic [1:0] op,
                                              input logic [63:0] old,
                                              input logic [63:0] wdata);
    case (op)
      CSR_RW:  csr_new_val = wdata;
      CSR_RS:  csr_new_val = old | wdata;
      CSR_RC:  csr_new_val = old & ~wdata;
      default: csr_new_val = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_cycle_cnt.sv
// Free-running 64-bit cycle counter; a load overrides the increment for that cycle.
// Count wraps to zero after all-ones; no backpressure.
module csr_cycle_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_val,
  output logic [63:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= 64'd0;
    else if (load) count <= load_val;
    else           count <= count + 64'd1;
  end

endmodule

// File: rtl/csr_rw_unit.sv
// Machine CSR read-modify-write unit: IDLE->READ->WRITE->RESP, response 3 cycles after accept.
// req_ready only in IDLE; response held stable until rsp_ready.
module csr_rw_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_wdata,
  input  logic        req_src_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_illegal,
  input  logic [63:0] misa,
  input  logic [63:0] mvendorid,
  input  logic [63:0] marchid,
  input  logic [63:0] mimpid,
  input  logic [63:0] mhartid,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mscratch_o,
  output logic [63:0] mcycle_o
);

  csr_state_e  state;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [63:0] wdata_q;
  logic        src_zero_q;
  logic [63:0] old_val;
  logic        hit;
  logic        write_en;
  logic        illegal_c;
  logic        commit;
  logic [63:0] new_val;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    old_val = 64'd0;
    hit     = 1'b1;
    case (addr_q)
      CSR_MISA:      old_val = misa;
      CSR_MVENDORID: old_val = mvendorid;
      CSR_MARCHID:   old_val = marchid;
      CSR_MIMPID:    old_val = mimpid;
      CSR_MHARTID:   old_val = mhartid;
      CSR_MTVEC:     old_val = mtvec_o;
      CSR_MEPC:      old_val = mepc_o;
      CSR_MSCRATCH:  old_val = mscratch_o;
      CSR_MCYCLE:    old_val = mcycle_o;
      default:       hit     = 1'b0;
    endcase
  end

  assign write_en  = (op_q == CSR_RW) ||
                     (((op_q == CSR_RS) || (op_q == CSR_RC)) && !src_zero_q);
  assign illegal_c = !hit || (op_q == 2'b00) || (write_en && (addr_q[11:10] == 2'b11));

  // rsp_rdata holds the old value captured in READ, so it doubles as the RMW operand.
  assign new_val = csr_new_val(op_q, rsp_rdata, wdata_q);
  assign commit  = (state == ST_WRITE) && write_en && !rsp_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= 12'd0;
      op_q        <= 2'b00;
      wdata_q     <= 64'd0;
      src_zero_q  <= 1'b0;
      rsp_rdata   <= 64'd0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            op_q       <= req_op;
            wdata_q    <= req_wdata;
            src_zero_q <= req_src_zero;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          rsp_rdata   <= old_val;
          rsp_illegal <= illegal_c;
          state       <= ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  if (rsp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // misa writes are legal but have no storage, so they fall through the case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtvec_o    <= 64'd0;
      mepc_o     <= 64'd0;
      mscratch_o <= 64'd0;
    end else if (commit) begin
      case (addr_q)
        CSR_MTVEC:    mtvec_o    <= new_val & MTVEC_WARL;
        CSR_MEPC:     mepc_o     <= new_val & MEPC_WARL;
        CSR_MSCRATCH: mscratch_o <= new_val & MSCRATCH_WARL;
        default: ;
      endcase
    end
  end

  csr_cycle_cnt u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .load     (commit && (addr_q == CSR_MCYCLE)),
    .load_val (new_val),
    .count    (mcycle_o)
  );

endmodule
